// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame constants and default timings.
// Used by ps2_host_tx (optional watchdog enabled with PS2_TX_TIMEOUT_EN) and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int   PS2_FRAME_EDGES        = 11;
  localparam logic PS2_START_BIT          = 1'b0;
  localparam logic PS2_STOP_BIT           = 1'b1;
  localparam int   PS2_BITCNT_W           = 4;
  localparam int   PS2_WDOG_W             = 21;
  localparam int   PS2_INHIBIT_CYCLES_DEF = 10000;
  localparam int   PS2_TIMEOUT_CYCLES_DEF = 2000000;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pad level, with an optional falling-edge strobe.
// Flops reset to 1 so an idle (pulled-up) bus never produces a spurious edge.
module ps2_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = EDGE_EN ? (prev_q & ~sync_q) : 1'b0;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog of TIMEOUT_CYCLES clk cycles.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       busy
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  logic clk_sync, clk_fall, data_sync, data_fall_unused;

  ps2_sync_edge #(.EDGE_EN(1'b1)) u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (PS2_clk_in),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  ps2_sync_edge #(.EDGE_EN(1'b0)) u_data_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (PS2_data_in),
    .sync_out (data_sync),
    .fall     (data_fall_unused)
  );

  ps2_tx_state_e            state_q, state_d;
  logic [INH_W-1:0]         inh_q, inh_d;
  logic [PS2_BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [8:0]               shreg_q, shreg_d;
  logic                     ack_q, ack_d;
  logic                     clk_oe_q, clk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     done_q, done_d;
  logic                     ack_ok_q, ack_ok_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
`ifdef PS2_TX_TIMEOUT_EN
  logic [PS2_WDOG_W-1:0]    wd_q, wd_d;
`endif

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          shreg_d   = {ps2_odd_parity(tx_data), tx_data};
          inh_d     = '0;
          state_d   = ST_INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES < 2);
        end
      end
      ST_INHIBIT: begin
        inh_d     = inh_q + 1'b1;
        // Data is pulled low in the final inhibit cycle so the start bit is already set up.
        data_oe_d = (int'(inh_q) + 2 >= INHIBIT_CYCLES);
        if (int'(inh_q) == INHIBIT_CYCLES - 1) begin
          state_d   = ST_RTS;
          clk_oe_d  = 1'b0;
          data_oe_d = ~PS2_START_BIT;
          bitcnt_d  = '0;
        end
      end
      ST_RTS: begin
        if (clk_fall) begin
          state_d   = ST_SHIFT;
          bitcnt_d  = PS2_BITCNT_W'(1);
          data_oe_d = ~shreg_q[0];
          shreg_d   = {PS2_STOP_BIT, shreg_q[8:1]};
        end
      end
      ST_SHIFT: begin
        // Stop bits are shifted in behind the payload, so edge 10 releases data naturally.
        if (clk_fall) begin
          bitcnt_d  = bitcnt_q + 1'b1;
          data_oe_d = ~shreg_q[0];
          shreg_d   = {PS2_STOP_BIT, shreg_q[8:1]};
          if (bitcnt_q == PS2_BITCNT_W'(PS2_FRAME_EDGES - 2)) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          bitcnt_d  = PS2_BITCNT_W'(PS2_FRAME_EDGES);
          ack_d     = ~data_sync;
          data_oe_d = 1'b0;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (clk_sync && data_sync) begin
          done_d   = 1'b1;
          ack_ok_d = ack_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == ST_INHIBIT) begin
      wd_d = '0;
    end else if (state_q != ST_IDLE) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == PS2_WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        ack_ok_d  = 1'b0;
      end
    end
`endif

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inh_q     <= '0;
      bitcnt_q  <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      bitcnt_q  <= bitcnt_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
    shreg_q <= shreg_d;
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign PS2_clk_oe  = clk_oe_q;
  assign PS2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard drives the open-drain bus and records each frame.
// Watchdog checks run only when PS2_TX_TIMEOUT_EN is defined; otherwise the silent-device hang is checked.
module tb_ps2_host_tx;

  localparam int INH  = 2000;
  localparam int TMO  = 5000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_oe, data_oe, done, ack_ok, busy;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_pad, data_pad;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  assign clk_pad  = dev_clk & ~clk_oe;
  assign data_pad = dev_data & ~data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .PS2_clk_in  (clk_pad),
    .PS2_data_in (data_pad),
    .PS2_clk_oe  (clk_oe),
    .PS2_data_oe (data_oe),
    .done        (done),
    .ack_ok      (ack_ok),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line frame, index 0 = start bit: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic dev_xfer(input logic [7:0] b, input bit do_ack, input int inject_edge,
                          input int abort_edge, output bit aborted);
    int inh = 0;
    int doe = 0;
    int n = 0;
    logic [10:0] seen = '0;
    aborted = 1'b0;
    if (clk_oe !== 1'b1) begin
      check("inhibit_start", clk_oe, 1);
      return;
    end
    while (clk_oe === 1'b1 && inh < INH + 100) begin
      inh++;
      if (data_oe === 1'b1) doe++;
      @(negedge clk);
    end
    check("inhibit_len", inh, INH);
    check("data_low_in_inhibit_cycles", doe, 1);
    check("rts_data_oe", data_oe, 1);
    repeat (HALF) @(negedge clk);
    seen[0] = data_pad;
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0;
      if (e == abort_edge) begin
        repeat (5) @(negedge clk);
        aborted = 1'b1;
        return;
      end
      if (e == inject_edge) begin
        @(negedge clk);
        check("ready_low_while_busy", tx_ready, 0);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      seen[e] = data_pad;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check("frame_bits", {21'd0, seen}, {21'd0, frame_of(b)});
    if (do_ack) dev_data = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("ack_ok", ack_ok, {31'd0, do_ack});
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", tx_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    bit ab;
    logic [7:0] b;
    bit ak;
    int n;
    int dc;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_done", done, 0);
    check("rst_ack_ok", ack_ok, 0);
    rst = 1'b0;

    send(8'hED);
    check("busy_after_accept", busy, 1);
    dev_xfer(8'hED, 1'b1, 0, 0, ab);
    check("done_count_ed", done_cnt, 1);

    send(8'hFF);
    dev_xfer(8'hFF, 1'b0, 0, 0, ab);
    check("done_count_ff", done_cnt, 2);

    b = 8'($urandom);
    send(b);
    dev_xfer(b, 1'b1, 4, 0, ab);
    repeat (20) @(negedge clk);
    check("done_count_ignored_valid", done_cnt, 3);

    b = 8'($urandom);
    send(b);
    dev_xfer(b, 1'b1, 0, 5, ab);
    check("abort_reached", {31'd0, ab}, 1);
    rst     = 1'b1;
    dev_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_clk_oe", clk_oe, 0);
    check("abort_data_oe", data_oe, 0);
    check("abort_tx_ready", tx_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt, 3);

    send(8'hF4);
    dev_xfer(8'hF4, 1'b1, 0, 0, ab);
    check("done_count_f4", done_cnt, 4);

    for (int i = 0; i < 3; i++) begin
      b  = 8'($urandom);
      ak = 1'($urandom_range(0, 1));
      send(b);
      dev_xfer(b, ak, 0, 0, ab);
    end
    check("done_count_random", done_cnt, 7);

    // Device that never clocks.
    dc = done_cnt;
    send(8'($urandom));
    n = 0;
    while (clk_oe === 1'b1 && n < INH + 100) begin
      @(negedge clk);
      n++;
    end
    check("silent_inhibit_len", n, INH);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TMO);
    check("timeout_done", done, 1);
    check("timeout_ack_ok", ack_ok, 0);
    check("timeout_clk_oe", clk_oe, 0);
    check("timeout_data_oe", data_oe, 0);
    @(negedge clk);
    check("timeout_ready", tx_ready, 1);
    check("timeout_done_count", done_cnt, dc + 1);
`else
    repeat (TMO + 500) @(negedge clk);
    check("silent_busy", busy, 1);
    check("silent_data_oe", data_oe, 1);
    check("silent_clk_oe", clk_oe, 0);
    check("silent_no_done", done_cnt, dc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("silent_rst_ready", tx_ready, 1);
    check("silent_rst_data_oe", data_oe, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles for which PS2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, watchdog limit in clk cycles per transfer (20 ms at 100 MHz).
REQ-003 clk  in  1  system clock, single clock domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tx_data  in  8  command byte to send to the keyboard.
REQ-006 tx_valid  in  1  request; byte accepted when tx_valid and tx_ready are both high on a clk edge.
REQ-007 tx_ready  out  1  high only in IDLE.
REQ-008 PS2_clk_in, PS2_data_in  in  1 each  raw pad levels, asynchronous.
REQ-009 PS2_clk_oe, PS2_data_oe  out  1 each  1 = drive pad low (open-drain), 0 = release.
REQ-010 done  out  1  one-cycle pulse at end of every transfer, success or failure.
REQ-011 ack_ok  out  1  valid with done: 1 = device ACK seen, 0 = failure.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 PS2_clk_in/PS2_data_in SHALL pass a 2-flop synchronizer; clock falling edge detected on synchronized value (fall = prev 1, now 0); 3-cycle input latency.
REQ-014 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-015 IDLE: both oe = 0; on accept latch tx_data, compute odd parity (~^tx_data), go INHIBIT next cycle.
REQ-016 INHIBIT: PS2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles; PS2_data_oe = 1 asserted in last cycle of INHIBIT; then RTS.
REQ-017 RTS: PS2_clk_oe = 0, PS2_data_oe = 1 (start bit 0); on first falling edge enter SHIFT with bit index 0.
REQ-018 SHIFT: on falling edge n (n = 1..8) drive data bit n-1 (LSB first), n = 9 parity, n = 10 stop (PS2_data_oe = 0); data_oe = ~bit; held until next falling edge.
REQ-019 After stop bit driven, next falling edge enters ACK sampling: synchronized PS2_data_in = 0 -> ack flag 1, else 0; go WAIT_IDLE.
REQ-020 WAIT_IDLE: both oe = 0; when synchronized clk and data both 1 -> pulse done with ack_ok = ack flag, return IDLE, tx_ready high next cycle.
REQ-021 A 4-bit bit counter SHALL count falling edges 0..11 in SHIFT/ACK and clear on entering RTS; no wrap beyond 11.
REQ-022 tx_valid while busy SHALL be ignored; no queueing; tx_data sampled only at accept.
REQ-023 Back-to-back: tx_valid held high in IDLE with done pulse SHALL start the next transfer no earlier than the cycle after done.

Reset
REQ-024 On rst: state IDLE, PS2_clk_oe = 0, PS2_data_oe = 0, tx_ready = 1, busy = 0, done = 0, ack_ok = 0, counters and synchronizers cleared to idle (sync flops = 1).
REQ-025 rst mid-transfer SHALL release both lines the cycle after rst is sampled; no done pulse emitted.

Configuration
REQ-026 Macro PS2_TX_TIMEOUT_EN defined: 21-bit watchdog cleared on entering INHIBIT, counts in RTS/SHIFT/ACK/WAIT_IDLE; reaching TIMEOUT_CYCLES -> release both lines, done = 1, ack_ok = 0, return IDLE.
REQ-027 Macro undefined: no watchdog logic; a silent device leaves the block in RTS indefinitely (only rst recovers).

Structure
REQ-028 Shared package ps2_pkg SHALL hold the state encoding, PS2 frame constants (11 falling edges, start 0, stop 1) and default INHIBIT/TIMEOUT values; the keyboard receiver shares frame constants.
REQ-029 One sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge strobe), instantiated for clock and, without edge output, data.

Verification
REQ-030 Send 0xED with device model ACK -> clk_oe low 10000 cycles, data bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop released, done with ack_ok = 1.
REQ-031 Send 0xFF, device holds data high at ACK edge -> parity 1 driven, done with ack_ok = 0.
REQ-032 tx_valid pulses during SHIFT with 0x00 -> ignored; only original byte observed on line, one done.
REQ-033 rst asserted after 5th falling edge -> both oe = 0 next cycle, tx_ready = 1, no done; subsequent 0xF4 transfer completes with ack_ok = 1.
REQ-034 PS2_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES = 5000, device never clocks -> done with ack_ok = 0 exactly 5000 cycles after leaving INHIBIT, lines released.
